// File: rtl/stft_pkg.sv
// stft_pkg: shared constants and the twiddle-sequencer state type for the STFT engine.
package stft_pkg;
    localparam int HALF_DEG_PER_TURN = 720;
    localparam int ROM_DEPTH         = 721;
    localparam int SIN_OFFSET_HALF   = 540;

    typedef enum logic [2:0] {IDLE, COS_RD, SIN_RD, CAP, OUT} tw_state_e;
endpackage

// File: rtl/stft_phase_to_index.sv
// stft_phase_to_index: maps phase p (turn/N units) to rounded half-degree cosine ROM indices.
// Ports: p (phase, LOG2N bits) -> idx_c (0..720); idx_s (sin index, 0..719) only when
// STFT_TWIDDLE_SIN_EN is defined.
module stft_phase_to_index
    import stft_pkg::*;
#(
    parameter int LOG2N = 8
) (
    input  logic [LOG2N-1:0] p,
    output logic [9:0]       idx_c
`ifdef STFT_TWIDDLE_SIN_EN
    ,
    output logic [9:0]       idx_s
`endif
);
    localparam int PW = LOG2N + 10;

    // Adding N/2 before the shift rounds to the nearest half degree.
    always_comb idx_c = 10'((PW'(p) * PW'(HALF_DEG_PER_TURN) + PW'(1 << (LOG2N - 1))) >> LOG2N);

`ifdef STFT_TWIDDLE_SIN_EN
    logic [10:0] s;

    // sin(x) = cos(x + 270 deg); 720 aliases 0 before the offset so the result stays in 0..719.
    always_comb begin
        s     = (idx_c == 10'(HALF_DEG_PER_TURN) ? 11'd0 : {1'b0, idx_c}) + 11'(SIN_OFFSET_HALF);
        idx_s = s >= 11'(HALF_DEG_PER_TURN) ? 10'(s - 11'(HALF_DEG_PER_TURN)) : s[9:0];
    end
`endif
endmodule

// File: rtl/stft_twiddle_seq.sv
// stft_twiddle_seq: sweeps bin k (outer) and sample n (inner), reads cos (and optionally sin)
// from the shared half-degree cosine ROM and streams {cos, sin, k, n} on a valid/ready port.
// Ports: clk, rst (sync, active-high); start/busy/done sweep control; rom_en, rom_deg_half,
// rom_data (registered ROM, one-cycle latency); out_valid/out_ready handshake carrying
// out_cos, out_sin, out_k, out_n, out_last (final word of the sweep).
// Build option: STFT_TWIDDLE_SIN_EN adds the sine read; without it out_sin is 0.
module stft_twiddle_seq
    import stft_pkg::*;
#(
    parameter int LOG2N    = 8,
    parameter int NUM_BINS = 129
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rom_en,
    output logic [9:0]              rom_deg_half,
    input  logic signed [15:0]      rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [15:0]      out_cos,
    output logic signed [15:0]      out_sin,
    output logic [LOG2N-1:0]        out_k,
    output logic [LOG2N-1:0]        out_n,
    output logic                    out_last
);
    tw_state_e          state_q, state_d;
    logic [LOG2N-1:0]   k_q, k_d, n_q, n_d, p_q, p_d;
    logic signed [15:0] cos_q, cos_d;
    logic               done_q, done_d;
    logic [9:0]         idx_c;
    logic               is_last;
`ifdef STFT_TWIDDLE_SIN_EN
    logic signed [15:0] sin_q, sin_d;
    logic [9:0]         idx_s;
`endif

    stft_phase_to_index #(.LOG2N(LOG2N)) u_idx (
        .p     (p_q),
        .idx_c (idx_c)
`ifdef STFT_TWIDDLE_SIN_EN
        ,
        .idx_s (idx_s)
`endif
    );

    // n = N-1 is all ones, so n + 1 wraps to 0 exactly when k must advance.
    assign is_last = (k_q == LOG2N'(NUM_BINS - 1)) && (&n_q);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        p_d          = p_q;
        cos_d        = cos_q;
        done_d       = 1'b0;
        rom_en       = 1'b0;
        rom_deg_half = '0;
`ifdef STFT_TWIDDLE_SIN_EN
        sin_d        = sin_q;
`endif
        case (state_q)
            IDLE: state_d = start ? COS_RD : IDLE;
            COS_RD: begin
                rom_en       = 1'b1;
                rom_deg_half = idx_c;
`ifdef STFT_TWIDDLE_SIN_EN
                state_d      = SIN_RD;
`else
                state_d      = CAP;
`endif
            end
`ifdef STFT_TWIDDLE_SIN_EN
            SIN_RD: begin
                rom_en       = 1'b1;
                rom_deg_half = idx_s;
                cos_d        = rom_data;
                state_d      = CAP;
            end
`endif
            CAP: begin
`ifdef STFT_TWIDDLE_SIN_EN
                sin_d   = rom_data;
`else
                cos_d   = rom_data;
`endif
                state_d = OUT;
            end
            OUT: if (out_ready) begin
                state_d = is_last ? IDLE : COS_RD;
                done_d  = is_last;
                n_d     = is_last ? '0 : n_q + 1'b1;
                k_d     = is_last ? '0 : (&n_q ? k_q + 1'b1 : k_q);
                // Phase accumulates k per sample instead of multiplying k*n.
                p_d     = (is_last || &n_q) ? '0 : p_q + k_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            cos_q   <= '0;
            done_q  <= 1'b0;
`ifdef STFT_TWIDDLE_SIN_EN
            sin_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            p_q     <= p_d;
            cos_q   <= cos_d;
            done_q  <= done_d;
`ifdef STFT_TWIDDLE_SIN_EN
            sin_q   <= sin_d;
`endif
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign out_valid = state_q == OUT;
    assign out_cos   = cos_q;
    assign out_k     = k_q;
    assign out_n     = n_q;
    assign out_last  = out_valid && is_last;
`ifdef STFT_TWIDDLE_SIN_EN
    assign out_sin   = sin_q;
`else
    assign out_sin   = '0;
`endif
endmodule

// File: tb/tb_stft_twiddle_seq.sv
// tb_stft_twiddle_seq: scoreboard bench for stft_twiddle_seq (N=256 and N=4 instances) and
// standalone stft_phase_to_index.
module tb_stft_twiddle_seq;
    import stft_pkg::*;

`ifdef STFT_TWIDDLE_SIN_EN
    localparam bit SIN_EN = 1'b1;
`else
    localparam bit SIN_EN = 1'b0;
`endif
    localparam int PER = SIN_EN ? 4 : 3;

    typedef struct {
        int k;
        int n;
        int cs;
        int sn;
        bit last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    logic signed [15:0] rom [ROM_DEPTH];

    // N = 256, NUM_BINS = 129 instance
    logic               a_start = 1'b0, a_ready = 1'b0;
    logic               a_busy, a_done, a_rom_en, a_valid, a_last;
    logic [9:0]         a_addr;
    logic signed [15:0] a_rom_data = '0, a_cos, a_sin;
    logic [7:0]         a_k, a_n;

    // N = 4, NUM_BINS = 2 instance
    logic               b_start = 1'b0, b_ready = 1'b0;
    logic               b_busy, b_done, b_rom_en, b_valid, b_last;
    logic [9:0]         b_addr;
    logic signed [15:0] b_rom_data = '0, b_cos, b_sin;
    logic [1:0]         b_k, b_n;

    logic [7:0] u_p = '0;
    logic [9:0] u_c;
`ifdef STFT_TWIDDLE_SIN_EN
    logic [9:0] u_s;
`endif

    stft_twiddle_seq #(.LOG2N(8), .NUM_BINS(129)) dut (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rom_en(a_rom_en), .rom_deg_half(a_addr), .rom_data(a_rom_data),
        .out_valid(a_valid), .out_ready(a_ready), .out_cos(a_cos), .out_sin(a_sin),
        .out_k(a_k), .out_n(a_n), .out_last(a_last)
    );

    stft_twiddle_seq #(.LOG2N(2), .NUM_BINS(2)) dut_s (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rom_en(b_rom_en), .rom_deg_half(b_addr), .rom_data(b_rom_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_cos(b_cos), .out_sin(b_sin),
        .out_k(b_k), .out_n(b_n), .out_last(b_last)
    );

    stft_phase_to_index #(.LOG2N(8)) u_idx (
        .p(u_p),
        .idx_c(u_c)
`ifdef STFT_TWIDDLE_SIN_EN
        ,
        .idx_s(u_s)
`endif
    );

    always @(posedge clk) if (a_rom_en) a_rom_data <= rom[a_addr];
    always @(posedge clk) if (b_rom_en) b_rom_data <= rom[b_addr];

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx_c_f(int p, int lg);
        return (p * 720 + (1 << (lg - 1))) >> lg;
    endfunction

    function automatic int idx_s_f(int c);
        return ((c == 720 ? 0 : c) + 540) % 720;
    endfunction

    word_t qa[$], qb[$];
    int    addr_qa[$], addr_qb[$];

    function automatic void push_word(bit is_b, int i);
        int lg = is_b ? 2 : 8;
        int k = i >> lg;
        int n = i % (1 << lg);
        int c = idx_c_f((k * n) % (1 << lg), lg);
        int s = idx_s_f(c);
        word_t w;
        w.k    = k;
        w.n    = n;
        w.cs   = int'(rom[c]);
        w.sn   = SIN_EN ? int'(rom[s]) : 0;
        w.last = is_b ? (k == 1 && n == 3) : (k == 128 && n == 255);
        if (is_b) begin
            addr_qb.push_back(c);
            if (SIN_EN) addr_qb.push_back(s);
            qb.push_back(w);
        end else begin
            addr_qa.push_back(c);
            if (SIN_EN) addr_qa.push_back(s);
            qa.push_back(w);
        end
    endfunction

    // Scoreboard for the N = 256 instance
    int cyc = 0, a_hs = 0, a_last_cyc = 0, a_bad = 0, a_gap_bad = 0;
    always @(negedge clk) begin
        int e;
        word_t w;
        cyc++;
        if (mon_on) begin
            if (a_rom_en) begin
                if (addr_qa.size() > 0) e = addr_qa.pop_front(); else e = -1;
                check("a_rom_addr", a_addr, e);
            end else if (a_addr != 0) a_bad++;
            if (a_done) a_bad++;
            if (a_valid && a_ready) begin
                if (qa.size() > 0) w = qa.pop_front(); else w = '{-1, -1, 0, 0, 1'b0};
                check("a_k", a_k, w.k);
                check("a_n", a_n, w.n);
                check("a_cos", a_cos, w.cs);
                check("a_sin", a_sin, w.sn);
                check("a_last", a_last, w.last);
                if (a_hs >= 1 && a_hs < 855 && cyc - a_last_cyc != PER) a_gap_bad++;
                a_last_cyc = cyc;
                a_hs++;
            end
        end
    end

    // Scoreboard for the N = 4 instance, plus stream-protocol tracking
    int b_hs = 0, b_dones = 0, b_bad = 0;
    logic b_pv = 1'b0, b_pr = 1'b0, b_pl = 1'b0;
    logic [1:0] b_pk = '0, b_pn = '0;
    logic signed [15:0] b_pc = '0, b_ps = '0;
    always @(negedge clk) begin
        int e;
        word_t w;
        if (mon_on) begin
            if (b_rom_en) begin
                if (addr_qb.size() > 0) e = addr_qb.pop_front(); else e = -1;
                check("b_rom_addr", b_addr, e);
            end else if (b_addr != 0) b_bad++;
            if (b_done) begin
                b_dones++;
                check("b_done_busy", b_busy, 0);
                check("b_done_valid", b_valid, 0);
            end
            if (b_pv && !b_pr && (!b_valid || b_rom_en || b_k != b_pk || b_n != b_pn ||
                b_cos != b_pc || b_sin != b_ps || b_last != b_pl)) b_bad++;
            if (b_valid && b_ready) begin
                if (qb.size() > 0) w = qb.pop_front(); else w = '{-1, -1, 0, 0, 1'b0};
                check("b_k", b_k, w.k);
                check("b_n", b_n, w.n);
                check("b_cos", b_cos, w.cs);
                check("b_sin", b_sin, w.sn);
                check("b_last", b_last, w.last);
                b_hs++;
            end
            b_pv = b_valid; b_pr = b_ready; b_pk = b_k; b_pn = b_n;
            b_pc = b_cos; b_ps = b_sin; b_pl = b_last;
        end
    end

    task automatic chk_zero_a(input string t);
        check({t, "_busy"}, a_busy, 0);
        check({t, "_done"}, a_done, 0);
        check({t, "_rom_en"}, a_rom_en, 0);
        check({t, "_addr"}, a_addr, 0);
        check({t, "_valid"}, a_valid, 0);
        check({t, "_cos"}, a_cos, 0);
        check({t, "_sin"}, a_sin, 0);
        check({t, "_k"}, a_k, 0);
        check({t, "_n"}, a_n, 0);
        check({t, "_last"}, a_last, 0);
    endtask

    // Called on the handshake edge: the next cycle is COS_RD, the one after SIN_RD (or CAP).
    task automatic rst_mid_a(input string t);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero_a(t);
        check({t, "_word_left"}, qa.size(), 1);
        check({t, "_addr_left"}, addr_qa.size(), 0);
        qa.delete();
        addr_qa.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int tp [5] = '{1, 64, 255, 2, 0};
    int tc [5] = '{3, 180, 717, 6, 0};
    int ts [5] = '{543, 0, 537, 546, 540};

    initial begin
        int lat, bad, n;
        logic signed [15:0] s_cos, s_sin;
        logic [7:0] s_k, s_n;
        for (int i = 0; i < ROM_DEPTH; i++)
            rom[i] = 16'(int'($cos(3.141592653589793 * i / 360.0) * 16384.0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk_zero_a("rst");
        check("rst_b_busy", b_busy, 0);
        check("rst_b_valid", b_valid, 0);

        for (int i = 0; i < 5; i++) begin
            u_p = 8'(tp[i]);
            #1;
            check("idx_c_pt", u_c, tc[i]);
`ifdef STFT_TWIDDLE_SIN_EN
            check("idx_s_pt", u_s, ts[i]);
`endif
        end
        for (int p = 0; p < 256; p++) begin
            u_p = 8'(p);
            #1;
            check("idx_c", u_c, idx_c_f(p, 8));
`ifdef STFT_TWIDDLE_SIN_EN
            check("idx_s", u_s, idx_s_f(idx_c_f(p, 8)));
`endif
        end

        // Sweep on the N = 256 instance up to and past the k = 3, n = 86 wrap point.
        for (int i = 0; i < 856; i++) push_word(1'b0, i);
        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        @(negedge clk);
        check("a_busy_t1", a_busy, 1);
        check("a_rom_en_t1", a_rom_en, 1);
        lat = 1;
        while (!a_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("a_valid_latency", lat, PER);
        check("a_first_cos", a_cos, 16384);
        check("a_first_sin", a_sin, 0);

        s_cos = a_cos; s_sin = a_sin; s_k = a_k; s_n = a_n;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!a_valid || a_rom_en || a_cos != s_cos || a_sin != s_sin || a_k != s_k || a_n != s_n) bad++;
        end
        check("a_backpressure_stable", bad, 0);
        @(posedge clk);
        #1 a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("a_cos_rd_after_hs", a_rom_en, 1);

        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;

        n = 0;
        while (a_hs < 855 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        check("a_hs_count", a_hs, 855);
        rst_mid_a("a_rst_sin");

        // Restart after reset must begin again at k = 0, n = 0.
        for (int i = 0; i < 5; i++) push_word(1'b0, i);
        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        n = 0;
        while (a_hs < 859 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("a_hs_restart", a_hs, 859);
        rst_mid_a("a_rst_again");
        check("a_gap", a_gap_bad, 0);
        check("a_misc", a_bad, 0);

        // Full sweep on the N = 4, NUM_BINS = 2 instance with random backpressure.
        for (int i = 0; i < 8; i++) push_word(1'b1, i);
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        n = 0;
        while (b_hs < 7 && n < 400) begin
            @(posedge clk);
            #1 b_ready = ($urandom_range(0, 3) != 0);
            b_start = (n == 9);
            n++;
        end
        b_start = 1'b0;
        b_ready = 1'b1;
        n = 0;
        while (!b_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", b_done, 1);
        // A start in the done cycle is accepted.
        for (int i = 0; i < 8; i++) push_word(1'b1, i);
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        @(negedge clk);
        check("b_restart_busy", b_busy, 1);
        check("b_restart_rom_en", b_rom_en, 1);
        check("b_dones_first", b_dones, 1);
        check("b_hs_first", b_hs, 8);
        n = 0;
        while (b_dones < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("b_dones_second", b_dones, 2);
        check("b_hs_second", b_hs, 16);
        check("b_words_left", qb.size(), 0);
        check("b_addr_left", addr_qb.size(), 0);
        check("b_protocol", b_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stft_twiddle_seq.md
# stft_twiddle_seq

Sequencer that generates the DFT twiddle stream for the STFT engine by driving the shared half-degree cosine ROM. For every bin k in 0..NUM_BINS-1 and sample n in 0..N-1, it computes the phase index, issues one cosine read and one sine read (sine optional) through the single ROM port, and presents {cos, sin, k, n} on a valid/ready stream to the multiply-accumulate stage.

## Interface
- LOG2N, 8: log2 of frame length N (N = 256).
- NUM_BINS, 129: number of bins swept; must satisfy 1 <= NUM_BINS <= N.
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle pulse; begins a sweep when idle.
- busy  out  1: high from the cycle after an accepted start until done.
- done  out  1: one-cycle pulse after the final output handshake.
- rom_en  out  1: ROM read enable.
- rom_deg_half  out  10: ROM address, half-degree units, 0..720.
- rom_data  in  16 signed: ROM output, registered, one-cycle latency, value = cos × 2^14.
- out_valid  out  1: twiddle word valid.
- out_ready  in  1: consumer accepts the word.
- out_cos, out_sin  out  16 signed each: twiddle value × 2^14.
- out_k, out_n  out  LOG2N each: bin and sample index of the current word.
- out_last  out  1: high with the word for k = NUM_BINS-1 and n = N-1.

## Operation
- Phase: p = (k·n) mod N. It is kept as an LOG2N-bit accumulator that is cleared at n = 0 and incremented by k on each n advance, with natural wrap. No multiplier is used for k·n.
- Cosine index: idx_c = (p·720 + N/2) >> LOG2N. This is the rounded value, ranging 0..720. The product is LOG2N+10 bits wide.
- Sine index: sin(x) = cos(x + 270°). Compute idx_s = (idx_c' + 540) mod 720, where idx_c' = 0 when idx_c = 720 and idx_c' = idx_c otherwise.
- FSM states:
  - IDLE → COS_RD on start.
  - COS_RD: rom_en = 1, address = idx_c. Next state is SIN_RD.
  - SIN_RD: rom_en = 1, address = idx_s. Latch out_cos <= rom_data. Next state is CAP.
  - CAP: rom_en = 0. Latch out_sin <= rom_data. Next state is OUT.
  - OUT: out_valid = 1. On out_ready:
    - advance n;
    - if n = N-1, set n = 0 and advance k;
    - if this was the final word, pulse done and go to IDLE; otherwise go to COS_RD.
- In every state other than COS_RD and SIN_RD: rom_en = 0 and rom_deg_half = 0.
- start while busy is ignored.
- Sweep order is k outer, n inner, beginning at k = 0, n = 0.

## Timing
- Reset values (all outputs 0): busy, done, rom_en, rom_deg_half, out_valid, out_cos, out_sin, out_k, out_n, out_last. The FSM resets to IDLE and the counters reset to 0.
- If start is sampled at edge t:
  - COS_RD address is driven in cycle t+1;
  - out_valid rises in cycle t+4.
- With out_ready held high, a word completes every 4 cycles.
- While out_valid = 1 and out_ready = 0, all out_* signals stay stable and the ROM is not read.
- out_valid never drops without a handshake.
- On the final handshake:
  - in the next cycle, done = 1, busy = 0 and out_valid = 0;
  - a start arriving in that same done cycle is accepted.
- rst during a sweep: the next cycle is IDLE with all outputs at their reset values. Any partial word is discarded.

## Configuration
- STFT_TWIDDLE_SIN_EN defined:
  - full behaviour as above.
- Undefined:
  - SIN_RD is removed, so the sequence is COS_RD → CAP → OUT;
  - CAP latches out_cos;
  - out_sin is tied to 0;
  - a word completes every 3 cycles;
  - the idx_s logic is not synthesized.

## Structure
- Shared package stft_pkg holds:
  - HALF_DEG_PER_TURN = 720;
  - ROM_DEPTH = 721;
  - SIN_OFFSET_HALF = 540;
  - the twiddle-sequencer state enum (IDLE, COS_RD, SIN_RD, CAP, OUT).
- One combinational sub-module, stft_phase_to_index, maps p to idx_c and idx_s so the bench can check it standalone.
- The ROM is external and instantiated alongside this block.

## Test plan
- Reset, then start with a ROM model. Expected for N = 256:
  - first word k = 0, n = 0, out_cos = 16384, out_sin = 0;
  - all words with k = 0 are identical.
- Index checks (address only):
  - k = 1, n = 1 → rom_deg_half = 3 (cos) then 543 (sin);
  - k = 64, n = 1 → 180 then 0;
  - k = 255, n = 1 → 717 then 537.
- Accumulator wrap: k = 3, n = 86. The accumulator holds 258 mod 256 = 2, so idx_c = 6.
- Backpressure: hold out_ready low for 10 cycles on a word.
  - outputs are stable and rom_en stays 0;
  - after release, the next COS_RD occurs the cycle after the handshake.
- Full sweep with NUM_BINS = 2 and LOG2N = 2:
  - exactly 8 words, in order (0,0)…(1,3);
  - out_last only on (1,3);
  - a single done pulse;
  - a start issued mid-sweep is ignored.
- rst asserted in SIN_RD: all outputs are 0 the next cycle. A subsequent start restarts at k = 0, n = 0.
